// File: rtl/park_pkg.sv
// park_pkg: shared constants and helpers for the parking-space allocator.
//   PARK_LOWEST_FIRST / PARK_ROUND_ROBIN : RR_MODE encodings
//   park_cnt_w(n) : width needed to hold a free-space count of 0..n
package park_pkg;
    localparam int PARK_LOWEST_FIRST = 0;
    localparam int PARK_ROUND_ROBIN  = 1;

    function automatic int park_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/park_free_finder.sv
// park_free_finder: combinational search for the first free space at or after start, wrapping.
//   free_mask : bit i = 1 means space i is free
//   start     : index where the search begins (0 gives lowest-first)
//   found     : at least one free space exists
//   idx       : index of the chosen free space
module park_free_finder #(
    parameter int N_SPACES = 8,
    parameter int IDX_W    = $clog2(N_SPACES)
) (
    input  logic [N_SPACES-1:0] free_mask,
    input  logic [IDX_W-1:0]    start,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_SPACES);
    logic [2*N_SPACES-1:0] dbl;
    logic [N_SPACES-1:0]   rot;
    logic [IDX_W-1:0]      pos;
    logic [IDX_W:0]        sum;
    always_comb begin
        // rotate so that start lands on bit 0, encode, then rotate the result back
        dbl = {free_mask, free_mask} >> start;
        rot = dbl[N_SPACES-1:0];
        pos = '0;
        for (int i = N_SPACES - 1; i >= 0; i--)
            if (rot[i]) pos = IDX_W'(i);
        sum   = {1'b0, pos} + {1'b0, start};
        idx   = sum >= N_L ? IDX_W'(sum - N_L) : sum[IDX_W-1:0];
        found = |free_mask;
    end
endmodule

// File: rtl/park_space_allocator.sv
// park_space_allocator: occupancy-tracking parking-space allocator with optional round-robin grants.
//   clk, rst_n (sync, active-low), enable
//   alloc_req -> alloc_valid / alloc_idx / alloc_fail (registered, 1-cycle latency)
//   rel_req, rel_idx -> rel_err (registered)
//   occupied, free_count, full, empty : registered lot status
module park_space_allocator
    import park_pkg::*;
#(
    parameter int N_SPACES = 8,
    parameter int IDX_W    = $clog2(N_SPACES),
    parameter int CNT_W    = park_cnt_w(N_SPACES),
    parameter int RR_MODE  = PARK_LOWEST_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                alloc_req,
    input  logic                rel_req,
    input  logic [IDX_W-1:0]    rel_idx,
    output logic                alloc_valid,
    output logic [IDX_W-1:0]    alloc_idx,
    output logic                alloc_fail,
    output logic                rel_err,
    output logic [N_SPACES-1:0] occupied,
    output logic [CNT_W-1:0]    free_count,
    output logic                full,
    output logic                empty
);
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_SPACES);
    logic [N_SPACES-1:0] occ_q, occ_d, rel_sh;
    logic [IDX_W-1:0]    ptr_q, ptr_d, idx_q, idx_d, start, fidx;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d, fail_q, fail_d, err_q, err_d;
    logic                full_q, full_d, empty_q, empty_d;
    logic                found, do_alloc, do_rel, rel_ok, grant;

    park_free_finder #(.N_SPACES(N_SPACES), .IDX_W(IDX_W)) u_finder (
        .free_mask(~occ_q),
        .start    (start),
        .found    (found),
        .idx      (fidx)
    );

    always_comb begin
        start    = RR_MODE == PARK_ROUND_ROBIN ? ptr_q : '0;
        do_alloc = enable & alloc_req;
        do_rel   = enable & rel_req;
        rel_sh   = occ_q >> rel_idx;
        // the search uses pre-edge occupancy, so a same-cycle release never frees a grantable space
        rel_ok   = do_rel & ({1'b0, rel_idx} < N_L) & rel_sh[0];
        grant    = do_alloc & found;
        occ_d    = (occ_q | (grant ? N_SPACES'(1) << fidx : '0))
                 & ~(rel_ok ? N_SPACES'(1) << rel_idx : '0);
        cnt_d    = cnt_q + CNT_W'(rel_ok) - CNT_W'(grant);
        ptr_d    = (RR_MODE == PARK_ROUND_ROBIN && grant)
                 ? (({1'b0, fidx} + 1'b1) == N_L ? '0 : fidx + 1'b1) : ptr_q;
        idx_d    = grant ? fidx : idx_q;
        valid_d  = grant;
        fail_d   = do_alloc & ~found;
        err_d    = do_rel & ~rel_ok;
        full_d   = cnt_d == '0;
        empty_d  = cnt_d == CNT_W'(N_SPACES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= CNT_W'(N_SPACES);
            idx_q   <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign occupied    = occ_q;
    assign free_count  = cnt_q;
    assign alloc_idx   = idx_q;
    assign alloc_valid = valid_q;
    assign alloc_fail  = fail_q;
    assign rel_err     = err_q;
    assign full        = full_q;
    assign empty       = empty_q;
endmodule

// File: tb/tb_park_space_allocator.sv
// tb_park_space_allocator: directed checks of lowest-first, round-robin and 10-space allocators.
module tb_park_space_allocator;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    logic a0 = 0, r0 = 0, a1 = 0, r1 = 0, a2 = 0, r2 = 0;
    logic [2:0] i0 = '0, i1 = '0;
    logic [3:0] i2 = '0;
    logic v0, f0, e0, fu0, em0, v1, f1, e1, fu1, em1, v2, f2, e2, fu2, em2;
    logic [2:0] x0, x1;
    logic [3:0] x2, c0, c1, c2;
    logic [7:0] o0, o1;
    logic [9:0] o2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    park_space_allocator #(.N_SPACES(8), .RR_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en), .alloc_req(a0), .rel_req(r0), .rel_idx(i0),
        .alloc_valid(v0), .alloc_idx(x0), .alloc_fail(f0), .rel_err(e0),
        .occupied(o0), .free_count(c0), .full(fu0), .empty(em0));
    park_space_allocator #(.N_SPACES(8), .RR_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .alloc_req(a1), .rel_req(r1), .rel_idx(i1),
        .alloc_valid(v1), .alloc_idx(x1), .alloc_fail(f1), .rel_err(e1),
        .occupied(o1), .free_count(c1), .full(fu1), .empty(em1));
    park_space_allocator #(.N_SPACES(10), .RR_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(en), .alloc_req(a2), .rel_req(r2), .rel_idx(i2),
        .alloc_valid(v2), .alloc_idx(x2), .alloc_fail(f2), .rel_err(e2),
        .occupied(o2), .free_count(c2), .full(fu2), .empty(em2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int u, input logic a, input logic r, input logic [3:0] idx);
        {a0, r0, a1, r1, a2, r2} = '0;
        case (u)
            0: begin a0 = a; r0 = r; i0 = idx[2:0]; end
            1: begin a1 = a; r1 = r; i1 = idx[2:0]; end
            default: begin a2 = a; r2 = r; i2 = idx; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", o0, 0);
        chk("rst_cnt", c0, 8);
        chk("rst_empty", em0, 1);
        chk("rst_full", fu0, 0);
        chk("rst_idx", x0, 0);
        chk("rst_pulses", {v0, f0, e0}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drv(0, 1, 0, 0);
            chk("fill_valid", v0, 1);
            chk("fill_idx", x0, k);
            chk("fill_cnt", c0, 7 - k);
        end
        chk("fill_full", fu0, 1);
        chk("fill_occ", o0, 8'hFF);
        drv(0, 1, 0, 0);
        chk("ninth_fail", f0, 1);
        chk("ninth_valid", v0, 0);
        chk("ninth_occ", o0, 8'hFF);
        chk("ninth_idx_hold", x0, 7);
        drv(0, 0, 1, 3);
        chk("rel3_occ", o0, 8'hF7);
        chk("rel3_cnt", c0, 1);
        chk("rel3_err", e0, 0);
        chk("rel3_full", fu0, 0);
        drv(0, 1, 0, 0);
        chk("realloc_idx", x0, 3);
        chk("realloc_cnt", c0, 0);
        drv(0, 1, 1, 5);
        chk("simul_fail", f0, 1);
        chk("simul_err", e0, 0);
        chk("simul_cnt", c0, 1);
        chk("simul_occ", o0, 8'hDF);
        drv(0, 0, 1, 5);
        chk("relfree_err", e0, 1);
        chk("relfree_occ", o0, 8'hDF);
        chk("relfree_cnt", c0, 1);
        drv(0, 0, 0, 0);
        chk("err_onecycle", e0, 0);
        drv(1, 1, 0, 0);
        chk("rr_g0", x1, 0);
        drv(1, 1, 0, 0);
        chk("rr_g1", x1, 1);
        drv(1, 0, 1, 0);
        chk("rr_rel0", o1, 8'h02);
        drv(1, 1, 0, 0);
        chk("rr_g2", x1, 2);
        chk("rr_g2_valid", v1, 1);
        drv(1, 1, 0, 0);
        chk("rr_ptr3", x1, 3);
        chk("rr_occ", o1, 8'h0E);
        drv(2, 1, 0, 0);
        drv(2, 1, 0, 0);
        chk("n10_occ", o2, 10'h003);
        chk("n10_cnt", c2, 8);
        drv(2, 0, 1, 2);
        chk("n10_free2_err", e2, 1);
        chk("n10_free2_occ", o2, 10'h003);
        drv(2, 0, 1, 12);
        chk("n10_oor_err", e2, 1);
        chk("n10_oor_cnt", c2, 8);
        drv(2, 0, 1, 9);
        chk("n10_free9_err", e2, 1);
        drv(2, 0, 1, 1);
        chk("n10_rel1_ok", {e2, o2}, {1'b0, 10'h001});
        en = 1'b0;
        drv(0, 1, 1, 0);
        chk("dis_occ", o0, 8'hDF);
        chk("dis_cnt", c0, 1);
        chk("dis_pulses", {v0, f0, e0}, 0);
        en = 1'b1;
        rst_n = 1'b0;
        drv(0, 1, 0, 0);
        chk("mid_rst_occ", o0, 0);
        chk("mid_rst_cnt", c0, 8);
        chk("mid_rst_empty", em0, 1);
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_rr_occ", o1, 0);
        rst_n = 1'b1;
        drv(1, 1, 0, 0);
        chk("rr_ptr_reset", x1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/park_space_allocator.md
# park_space_allocator

Sequential, parametrised parking-space allocator. It keeps an occupancy register for `N_SPACES` spaces, grants a free space on an entry request, and frees a space on an exit request. It also reports the free-space count and full/empty status. It sits between the gate controller and the display/billing logic, and supersedes the stateless lowest-free-index encoder by owning the occupancy state and adding a round-robin mode.

## Interface
- `N_SPACES`, default 8: number of spaces; legal range 2..64.
- `IDX_W`, default `$clog2(N_SPACES)`: width of a space index.
- `CNT_W`, default `$clog2(N_SPACES+1)`: width of the free-space count.
- `RR_MODE`, default 0: 0 = lowest free index first; 1 = round-robin search starting at the rotating pointer.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `enable`, in, 1: block enable; when 0, requests are ignored and state is held.
- `alloc_req`, in, 1: entry request, one cycle per car.
- `rel_req`, in, 1: exit request.
- `rel_idx`, in, `IDX_W`: space being vacated.
- `alloc_valid`, out, 1: one-cycle pulse; a space was granted.
- `alloc_idx`, out, `IDX_W`: granted index; holds its last value between grants.
- `alloc_fail`, out, 1: one-cycle pulse; request arrived while the lot was full.
- `rel_err`, out, 1: one-cycle pulse; release of a free space or an out-of-range index.
- `occupied`, out, `N_SPACES`: occupancy register; bit i = 1 means space i is taken.
- `free_count`, out, `CNT_W`: number of zero bits in `occupied`.
- `full`, out, 1: `free_count == 0`.
- `empty`, out, 1: `free_count == N_SPACES`.

## Operation
- Reset values: `occupied = 0`, `free_count = N_SPACES`, `empty = 1`, `full = 0`, `alloc_idx = 0`, all pulses 0, round-robin pointer 0.
- Allocation: on `alloc_req & enable`, search the current (pre-edge) `occupied` for a zero bit.
  - `RR_MODE=0`: pick the lowest zero index.
  - `RR_MODE=1`: pick the first zero index at or above the pointer, wrapping past `N_SPACES-1` to 0; then set pointer = granted index + 1, wrapping to 0.
- Successful grant: set the occupied bit, pulse `alloc_valid`, load `alloc_idx`.
- No zero bit found: pulse `alloc_fail`; state is unchanged and the pointer does not move.
- Release: on `rel_req & enable`:
  - if `rel_idx < N_SPACES` and that bit is 1, clear the bit;
  - otherwise pulse `rel_err` and change nothing.
- Simultaneous alloc and release: both take effect in the same cycle.
  - The allocator searches the pre-edge occupancy, so the space being freed is not grantable that cycle. In a full lot, alloc fails while the release succeeds.
  - A release targeting the index just granted in the same cycle cannot occur, because that bit was 0 pre-edge; the release is flagged `rel_err`.
- `free_count` is updated incrementally: +1 per valid release, −1 per grant, net 0 when both happen. It must always equal the popcount of `~occupied`.
- `enable = 0`: no state change and no pulses. In-flight responses already registered still appear on the following cycle.
- Reset asserted mid-operation wins over any request on the same edge.

## Timing
- Latency is 1 cycle: a request sampled on edge k produces its response pulse, and updated `occupied`, `free_count`, `full` and `empty`, valid after edge k.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back `alloc_req` every cycle is supported: each search sees the occupancy updated by the previous grant.
- Pulses are exactly one cycle wide per request and never overlap for the same request type.

## Structure
- Shared package `park_pkg`:
  - the `RR_MODE` encoding constants (`PARK_LOWEST_FIRST = 0`, `PARK_ROUND_ROBIN = 1`);
  - a function for the free-space count width.
- Sub-module `park_free_finder`:
  - purely combinational, parametrised by `N_SPACES`;
  - inputs: a free mask and a start index;
  - outputs: `found` and `idx`;
  - implemented as a rotate, priority-encode, un-rotate; start = 0 gives lowest-first.
- Top level holds the occupancy register, the pointer, the counter and the output registers.

## Test plan
- Reset then 8 consecutive `alloc_req` (`N_SPACES=8`, mode 0) -> `alloc_idx` 0..7 on consecutive cycles, `full=1`, `free_count=0`; a 9th request -> `alloc_fail`, `occupied=8'hFF`.
- From full, release index 3, then alloc -> `occupied` goes to `8'hF7`, then the grant returns idx 3 and `free_count` returns 1→0.
- Mode 1, from empty: alloc, alloc, release 0, alloc -> grants 0, 1, 2 (not 0); pointer = 3.
- Full lot, alloc and release idx 5 in the same cycle -> `alloc_fail=1`, release succeeds, `free_count=1`, bit 5 cleared.
- Release of a free index 2, and of index 9 with `N_SPACES=10`... (out of range with `N_SPACES=8`: idx 8 or above) -> `rel_err` pulse, `occupied` and `free_count` unchanged.
- `enable=0` with alloc and release pulses, then `rst_n=0` asserted mid-sequence -> no change while disabled; after reset `occupied=0`, `free_count=N_SPACES`, `empty=1`.
